// File: rtl/tbt_pkg.sv
// Shared definitions for the 2x2 tile datapath (loader, adder, serializer).
// Contents: the element width, the tile element count, the serializer state
// encoding, the emission-order type and the helper that maps an emission
// index to a buffer slot.
// Slot s holds element [s/2][s%2], i.e. bits s*WORD_W +: WORD_W of a tile.
package tbt_pkg;

  localparam int WORD_W = 32;
  localparam int TILE_N = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_REARM = 2'd3
  } state_t;

  typedef enum logic {
    ORDER_ROW = 1'b0,
    ORDER_COL = 1'b1
  } order_t;

  // Column-major order walks the transposed tile, which is the same as
  // swapping the two index bits (row bit <-> column bit).
  function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] idx,
                                               input order_t order);
    logic [IDX_W-1:0] slot;
    slot = (order == ORDER_COL) ? {idx[0], idx[1]} : idx;
    return slot;
  endfunction

endpackage

// File: rtl/tbt_result_serializer_if.sv
// Word stream from the tile serializer toward the memory writer.
// Signals:
//   out_data  - current element (WORD_W bits)
//   out_valid - out_data is valid
//   out_ready - sink accepts the word when high together with out_valid
//   out_last  - marks the fourth word of a tile
// Modports: master (serializer side), slave (sink side).
interface tbt_result_serializer_if #(
  parameter int WORD_W = 32
);

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/tbt_word_mux.sv
// Combinational 4:1 selector that picks the element for emission index idx
// out of a buffered 2x2 tile.
// Ports:
//   tile - buffered tile, slot s at bits s*WORD_W +: WORD_W
//   idx  - emission index 0..3
//   word - selected element
// Build option: TBT_SERIALIZER_COL_MAJOR_EN selects column-major emission
// order; row-major otherwise.
module tbt_word_mux #(
  parameter int WORD_W = tbt_pkg::WORD_W
) (
  input  logic [4*WORD_W-1:0] tile,
  input  logic [1:0]          idx,
  output logic [WORD_W-1:0]   word
);
  import tbt_pkg::*;

`ifdef TBT_SERIALIZER_COL_MAJOR_EN
  localparam order_t ORDER = ORDER_COL;
`else
  localparam order_t ORDER = ORDER_ROW;
`endif

  logic [1:0] slot;

  always_comb begin
    slot = slot_of(idx, ORDER);
    word = tile[0*WORD_W +: WORD_W];
    case (slot)
      2'd0: word = tile[0*WORD_W +: WORD_W];
      2'd1: word = tile[1*WORD_W +: WORD_W];
      2'd2: word = tile[2*WORD_W +: WORD_W];
      2'd3: word = tile[3*WORD_W +: WORD_W];
      default: word = tile[0*WORD_W +: WORD_W];
    endcase
  end

endmodule

// File: rtl/tbt_result_serializer.sv
// Tile result serializer: captures one 2x2 tile from the adder over the
// result_ready/result_ack handshake, then emits its four elements one word
// per beat on a valid/ready stream, so the adder is free as soon as the
// tile is captured.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   result_ready - adder presents a tile on result
//   result       - tile, element [i][j] at bits (i*2+j)*WORD_W +: WORD_W
//   result_ack   - one-cycle pulse, tile captured
//   tile_count   - tiles fully emitted, wraps silently
//   out_if       - word stream (out_data/out_valid/out_ready/out_last)
// Build option: TBT_SERIALIZER_COL_MAJOR_EN selects column-major emission
// order (handled in tbt_word_mux); row-major otherwise.
module tbt_result_serializer #(
  parameter int WORD_W = tbt_pkg::WORD_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   result_ready,
  input  logic [4*WORD_W-1:0]    result,
  output logic                   result_ack,
  output logic [CNT_W-1:0]       tile_count,
  tbt_result_serializer_if.master out_if
);
  import tbt_pkg::*;

  state_t              state, state_n;
  logic [1:0]          idx, idx_n;
  logic                seen_low, seen_low_n;
  logic                ack_n;
  logic                valid, valid_n;
  logic [CNT_W-1:0]    cnt_n;
  logic                load;
  logic                beat;
  logic [4*WORD_W-1:0] tile_buf;
  logic [WORD_W-1:0]   word;

  assign beat = valid && out_if.out_ready;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    seen_low_n = seen_low;
    ack_n      = 1'b0;
    valid_n    = valid;
    cnt_n      = tile_count;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (result_ready) begin
          load       = 1'b1;
          ack_n      = 1'b1;
          seen_low_n = 1'b0;
          state_n    = ST_ACK;
        end
      end
      ST_ACK: begin
        valid_n = 1'b1;
        idx_n   = 2'd0;
        state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The adder holds result_ready one cycle past the ack; remember
        // whether it has dropped so the same tile is not captured again.
        if (!result_ready) seen_low_n = 1'b1;
        if (beat) begin
          if (idx != 2'd3) begin
            idx_n = idx + 2'd1;
          end else begin
            valid_n = 1'b0;
            cnt_n   = tile_count + CNT_W'(1);
            state_n = (seen_low || !result_ready) ? ST_IDLE : ST_REARM;
          end
        end
      end
      ST_REARM: begin
        if (!result_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      seen_low   <= 1'b0;
      result_ack <= 1'b0;
      valid      <= 1'b0;
      tile_count <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      seen_low   <= seen_low_n;
      result_ack <= ack_n;
      valid      <= valid_n;
      tile_count <= cnt_n;
    end
  end

  // Data buffer carries no reset; it is only observable while valid is set.
  always_ff @(posedge clk) begin
    if (load) tile_buf <= result;
  end

  tbt_word_mux #(
    .WORD_W (WORD_W)
  ) u_word_mux (
    .tile (tile_buf),
    .idx  (idx),
    .word (word)
  );

  assign out_if.out_data  = valid ? word : '0;
  assign out_if.out_valid = valid;
  assign out_if.out_last  = valid && (idx == 2'd3);

endmodule

// File: tb/tb_tbt_result_serializer.sv
// Directed bench for tbt_result_serializer: reset state, single tile,
// back-pressure, lingering result_ready, REARM hold-off, reset mid-drain,
// reset/result_ready collision and tile_count wrap (2-bit counter).
// Honours TBT_SERIALIZER_COL_MAJOR_EN for the expected emission order.
module tb_tbt_result_serializer;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                result_ready = 1'b0;
  logic [4*WORD_W-1:0] result = '0;
  logic                result_ack;
  logic [CNT_W-1:0]    tile_count;

  tbt_result_serializer_if #(.WORD_W(WORD_W)) out_if ();

  tbt_result_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .result_ready (result_ready),
    .result       (result),
    .result_ack   (result_ack),
    .tile_count   (tile_count),
    .out_if       (out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int exp_cnt = 0;
  int ord [4];

  always @(posedge clk) if (result_ack) ack_cnt <= ack_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a tile, wait for the ack, then drain it under the out_ready
  // pattern pat (bit 0 first). result_ready stays high for the first
  // `linger` edges after the ack edge.
  task automatic run_tile(input logic [127:0] tile, input logic [6:0] pat,
                          input int linger, input string tag);
    logic [31:0] w [4];
    int a0;
    int beat;
    int i;
    for (int b = 0; b < 4; b++) w[b] = tile[ord[b]*32 +: 32];
    a0 = ack_cnt;
    beat = 0;
    result = tile;
    result_ready = 1'b1;
    out_if.out_ready = 1'b1;
    i = 0;
    while (!result_ack && i < 10) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_ack"}, 32'(result_ack), 32'd1);
    check({tag, "_ack_vld"}, 32'(out_if.out_valid), 32'd0);
    i = 0;
    while (beat < 4 && i < 40) begin
      result_ready = (i < linger);
      out_if.out_ready = (i >= 1 && i <= 7) ? pat[i-1] : 1'b1;
      if (i >= 1) begin
        check({tag, "_vld"}, 32'(out_if.out_valid), 32'd1);
        check({tag, "_data"}, out_if.out_data, w[beat]);
        check({tag, "_last"}, 32'(out_if.out_last), 32'(beat == 3));
        if (out_if.out_ready && out_if.out_valid) beat++;
      end
      @(negedge clk);
      i++;
    end
    check({tag, "_beats"}, 32'(beat), 32'd4);
    if (pat == 7'h7f) check({tag, "_cycles"}, 32'(i), 32'd5);
    exp_cnt = (exp_cnt + 1) % 4;
    check({tag, "_vld_off"}, 32'(out_if.out_valid), 32'd0);
    check({tag, "_cnt"}, 32'(tile_count), 32'(exp_cnt));
    repeat (3) @(negedge clk);
    check({tag, "_acks"}, 32'(ack_cnt - a0), 32'd1);
    result_ready = 1'b0;
    out_if.out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t;
`ifdef TBT_SERIALIZER_COL_MAJOR_EN
    ord = '{0, 2, 1, 3};
`else
    ord = '{0, 1, 2, 3};
`endif
    out_if.out_ready = 1'b1;
    // Reset held with a tile presented: reset wins, no ack.
    result = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(result_ack), 32'd0);
    check("rst_vld", 32'(out_if.out_valid), 32'd0);
    check("rst_last", 32'(out_if.out_last), 32'd0);
    check("rst_data", out_if.out_data, 32'd0);
    check("rst_cnt", 32'(tile_count), 32'd0);
    check("rst_acks", 32'(ack_cnt), 32'd0);
    reset = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);

    run_tile({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 7'h7f, 0, "single");
    run_tile({32'hDEADBEEF, 32'h7F800000, 32'h80000000, 32'h00000001}, 7'b1101001, 0, "bp");
    run_tile({32'hC0000000, 32'h00800000, 32'hFFFFFFFF, 32'h12345678}, 7'h7f, 2, "linger");

    // Reset during DRAIN once words 0 and 1 have been accepted.
    result = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    result_ready = 1'b1;
    t = 0;
    while (!result_ack && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("mid_ack", 32'(result_ack), 32'd1);
    result_ready = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_w2", out_if.out_data, (ord[2] == 2) ? 32'h33333333 : 32'h22222222);
    reset = 1'b1;
    result = {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001};
    result_ready = 1'b1;
    @(negedge clk);
    check("mid_vld", 32'(out_if.out_valid), 32'd0);
    check("mid_cnt", 32'(tile_count), 32'd0);
    check("mid_data", out_if.out_data, 32'd0);
    @(negedge clk);
    check("mid_noack", 32'(result_ack), 32'd0);
    reset = 1'b0;
    exp_cnt = 0;
    run_tile({32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001}, 7'h7f, 0, "fresh");

    // Counter wrap from a cleared counter: 1, 2, 3, 0, 1.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    run_tile({32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}, 7'h7f, 0, "wrap1");
    run_tile({32'h00000014, 32'h00000013, 32'h00000012, 32'h00000011}, 7'h7f, 100, "rearm");
    run_tile({32'h00000024, 32'h00000023, 32'h00000022, 32'h00000021}, 7'b1010101, 0, "wrap3");
    run_tile({32'h00000034, 32'h00000033, 32'h00000032, 32'h00000031}, 7'h7f, 0, "wrap4");
    run_tile({32'h00000044, 32'h00000043, 32'h00000042, 32'h00000041}, 7'h7f, 1, "wrap5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbt_result_serializer.md
# tbt_result_serializer

Downstream stage of the 2×2 tile adder. Accepts one completed 2×2 tile of IEEE-754 single-precision words over the adder's `result_ready`/`result_ack` handshake and buffers it. Emits the four elements one word per beat on a valid/ready stream toward the memory writer. Decouples the adder from output back-pressure so the adder can return to idle as soon as the tile is captured.

## Interface
Parameters:
- `WORD_W`, 32: element width in bits.
- `CNT_W`, 16: width of the tile counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `result_ready`  in  1  adder has a valid tile on `result`.
- `result`  in  4*WORD_W  tile; element [i][j] at bits `(i*2+j)*WORD_W +: WORD_W`.
- `result_ack`  out  1  one-cycle pulse; tile captured.
- `out_data`  out  WORD_W  current element.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the word when high with `out_valid`.
- `out_last`  out  1  high with the fourth word of a tile.
- `tile_count`  out  CNT_W  number of tiles fully emitted; wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: waiting for a tile.
  - ACK: capture cycle.
  - DRAIN: emitting words.
  - REARM: waiting for `result_ready` to deassert.
- IDLE, `result_ready`=1:
  - Load the 4-word buffer from `result`.
  - `result_ack`<=1, clear `seen_low`, go to ACK.
- ACK:
  - `result_ack`<=0 and `out_valid`<=1.
  - `out_data`<=word 0, `idx`<=0, go to DRAIN.
- DRAIN, `out_valid && out_ready`:
  - If `idx`<3: `idx`++ and present the next word.
  - If `idx`==3: `out_valid`<=0 and `tile_count`++.
  - After word 3: go to IDLE if `seen_low` is set or `result_ready`=0; otherwise go to REARM.
- DRAIN without `out_ready`: `out_data`, `out_valid`, `out_last` hold stable.
- REARM: go to IDLE on the first cycle `result_ready`=0.
- `seen_low` sets on any cycle after ACK where `result_ready`=0.
- Purpose of `seen_low` and REARM: the adder keeps `result_ready` high for one cycle after sampling the ack. The serializer never captures the same tile twice.
- `out_last` = `out_valid && idx==3`.
- Default emission order is row-major: [0][0], [0][1], [1][0], [1][1].
- No arithmetic on element data; words pass bit-exact.

## Timing
- Reset values: `result_ack`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `tile_count`=0, state IDLE, `idx`=0, `seen_low`=0.
- Latency with `out_ready` held high:
  - `result_ready` sampled at edge k.
  - `result_ack` is high between edges k and k+1.
  - Word 0 is valid from edge k+1.
  - Word 3 is accepted at edge k+5.
  - The next tile can be sampled in IDLE at edge k+6 at the earliest.
- `result_ready` is ignored outside IDLE; only one tile is in flight.
- Reset mid-DRAIN:
  - Buffer contents are abandoned; `out_valid` drops on the next edge.
  - `tile_count` clears.
  - A tile still presented after reset is captured afresh from IDLE.
- `result_ready` and `reset` high together: reset wins; no ack is issued.
- `tile_count` wraps from 2^CNT_W−1 to 0 without a flag.

## Configuration
- Macro: `TBT_SERIALIZER_COL_MAJOR_EN`.
- Defined: emission order is column-major, [0][0], [1][0], [0][1], [1][1] (transposed tile). `out_last` still marks the fourth word.
- Undefined: row-major order as above.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `tbt_pkg`:
  - `WORD_W`.
  - Tile element count (4).
  - State encoding constants: IDLE, ACK, DRAIN, REARM.
  - Helper that maps (`idx`, order) to a buffer slot.
  - Also reused by the adder and the upstream loader.
- One sub-module: `tbt_word_mux`, a combinational 4:1 word selector driven by `idx` and the order macro. All other logic is in the top module.

## Test plan
- Single tile, row-major build:
  - Stimulus: `result`={40800000,40400000,40000000,3F800000} (MSB→LSB), `out_ready`=1.
  - Required: one `result_ack` pulse; words 3F800000, 40000000, 40400000, 40800000 on consecutive cycles; `out_last` on the fourth; `tile_count`=1.
- Column-major build, same tile:
  - Required: words 3F800000, 40400000, 40000000, 40800000.
- Back-pressure:
  - Stimulus: `out_ready` toggling 1,0,0,1,0,1,1.
  - Required: each word holds stable while stalled; exactly 4 accepted beats; no skipped or duplicated words.
- Lingering `result_ready`:
  - Stimulus: `result_ready` stays high 1 cycle after the ack.
  - Required: exactly one capture and one `result_ack`; `tile_count` increments once.
- Reset during DRAIN after word 1:
  - Required: `out_valid`=0 and `tile_count`=0 next cycle.
  - A fresh tile afterwards emits from word 0.
- `tile_count` wrap:
  - Stimulus: preload `CNT_W`=2; stream 5 tiles.
  - Required: `tile_count` sequence 1, 2, 3, 0, 1.
